// File: rtl/replica_pkg.sv
// Shared replica-level types for the salesman annealer: problem size, move
// record, com encoding, delta type and the two_opt_delta state encoding.
package replica_pkg;

    localparam int city_num = 7;
    localparam int city_log = $clog2(city_num + 2);
    localparam int dist_w   = 8;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        TWO = 2'd1,
        THR = 2'd2
    } com_t;

    typedef struct packed {
        com_t                com;
        logic [3:0]          base_id;
        logic [city_log-1:0] K;
        logic [city_log-1:0] L;
        logic [15:0]         r_metropolis;
        logic [15:0]         r_exchange;
    } opt_t;

    typedef logic signed [dist_w+1:0] delta_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ORD  = 2'd1,
        RD_DIST = 2'd2,
        DONE    = 2'd3
    } tod_state_t;

endpackage

// File: rtl/two_opt_delta_if.sv
// Move-in / delta-out handshakes plus the ordering and distance memory read
// ports of one two_opt_delta instance. slave = the block, master = its environment.
interface two_opt_delta_if
    import replica_pkg::*;
#(
    parameter int DIST_W   = dist_w,
    parameter int CITY_LOG = $clog2(city_num + 2)
) ();

    logic                     in_valid;
    logic                     in_ready;
    opt_t                     opt_i;
    logic [CITY_LOG-1:0]      ord_raddr;
    logic [CITY_LOG-1:0]      ord_rdata;
    logic [2*CITY_LOG-1:0]    dist_raddr;
    logic [DIST_W-1:0]        dist_rdata;
    logic                     out_valid;
    logic                     out_ready;
    opt_t                     opt_o;
    logic signed [DIST_W+1:0] delta;

    modport slave (
        input  in_valid, opt_i, ord_rdata, dist_rdata, out_ready,
        output in_ready, ord_raddr, dist_raddr, out_valid, opt_o, delta
    );

    modport master (
        output in_valid, opt_i, ord_rdata, dist_rdata, out_ready,
        input  in_ready, ord_raddr, dist_raddr, out_valid, opt_o, delta
    );

endinterface

// File: rtl/two_opt_delta.sv
// 2-opt tour-length delta for one annealer replica: reads o[K-1],o[K],o[L],o[L+1],
// then four distances. Define TWO_OPT_DIST_PIPE_EN for a registered-output distance RAM.
module two_opt_delta
    import replica_pkg::*;
#(
    parameter int DIST_W   = dist_w,
    parameter int CITY_LOG = $clog2(city_num + 2)
) (
    input  logic            clk,
    input  logic            reset,
    two_opt_delta_if.slave  bus
);

`ifdef TWO_OPT_DIST_PIPE_EN
    localparam logic [2:0] ACC_OFF = 3'd2;
`else
    localparam logic [2:0] ACC_OFF = 3'd1;
`endif
    localparam logic [2:0] ORD_LAST  = 3'd4;
    localparam logic [2:0] DIST_LAST = 3'd3 + ACC_OFF;
    localparam logic [CITY_LOG-1:0] ONE_A = {{(CITY_LOG-1){1'b0}}, 1'b1};

    tod_state_t                      state_r, state_s;
    logic [2:0]                      cnt_r, cnt_s;
    logic [2:0]                      acc_idx_s;
    opt_t                            opt_r, opt_s;
    logic signed [DIST_W+1:0]        acc_r, acc_s;
    logic signed [DIST_W+1:0]        d_ext_s;
    logic [3:0][CITY_LOG-1:0]        city_r, city_s;
    logic [CITY_LOG-1:0]             ord_raddr_r, ord_raddr_s;
    logic [2*CITY_LOG-1:0]           dist_raddr_r, dist_raddr_s;
    logic                            in_ready_r, in_ready_s;
    logic                            out_valid_r, out_valid_s;
    logic [DIST_W-1:0]               dist_use_s;

`ifdef TWO_OPT_DIST_PIPE_EN
    logic [DIST_W-1:0]               dist_q_r;

    // Re-time distance data coming from a registered-output RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dist_q_r <= '0;
        end else begin
            dist_q_r <= bus.dist_rdata;
        end
    end

    assign dist_use_s = dist_q_r;
`else
    assign dist_use_s = bus.dist_rdata;
`endif

    assign d_ext_s = $signed({2'b00, dist_use_s});

    // Next-state, address sequencing, city capture and delta accumulation.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        opt_s        = opt_r;
        acc_s        = acc_r;
        city_s       = city_r;
        ord_raddr_s  = ord_raddr_r;
        dist_raddr_s = dist_raddr_r;
        acc_idx_s    = cnt_r - ACC_OFF;

        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    opt_s = bus.opt_i;
                    acc_s = '0;
                    cnt_s = 3'd0;
                    if (bus.opt_i.com == TWO) begin
                        state_s     = RD_ORD;
                        ord_raddr_s = CITY_LOG'(bus.opt_i.K) - ONE_A;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            RD_ORD: begin
                // Data for the address issued last cycle is on ord_rdata now.
                if (cnt_r != 3'd0) begin
                    city_s[2'(cnt_r - 3'd1)] = bus.ord_rdata;
                end else begin
                    city_s = city_r;
                end
                case (cnt_r)
                    3'd0:    ord_raddr_s = CITY_LOG'(opt_r.K);
                    3'd1:    ord_raddr_s = CITY_LOG'(opt_r.L);
                    3'd2:    ord_raddr_s = CITY_LOG'(opt_r.L) + ONE_A;
                    default: ord_raddr_s = ord_raddr_r;
                endcase
                if (cnt_r == ORD_LAST) begin
                    state_s      = RD_DIST;
                    cnt_s        = 3'd0;
                    dist_raddr_s = {city_r[0], city_r[2]};
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end

            RD_DIST: begin
                case (cnt_r)
                    3'd0:    dist_raddr_s = {city_r[1], city_r[3]};
                    3'd1:    dist_raddr_s = {city_r[0], city_r[1]};
                    3'd2:    dist_raddr_s = {city_r[2], city_r[3]};
                    default: dist_raddr_s = dist_raddr_r;
                endcase
                // New edges are added, removed edges subtracted.
                if (cnt_r >= ACC_OFF) begin
                    if (acc_idx_s < 3'd2) begin
                        acc_s = acc_r + d_ext_s;
                    end else begin
                        acc_s = acc_r - d_ext_s;
                    end
                end else begin
                    acc_s = acc_r;
                end
                if (cnt_r == DIST_LAST) begin
                    state_s = DONE;
                    cnt_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase

        in_ready_s  = (state_s == IDLE);
        out_valid_s = (state_s == DONE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered output flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r        <= 3'd0;
            opt_r        <= '0;
            acc_r        <= '0;
            city_r       <= '0;
            ord_raddr_r  <= '0;
            dist_raddr_r <= '0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
        end else begin
            cnt_r        <= cnt_s;
            opt_r        <= opt_s;
            acc_r        <= acc_s;
            city_r       <= city_s;
            ord_raddr_r  <= ord_raddr_s;
            dist_raddr_r <= dist_raddr_s;
            in_ready_r   <= in_ready_s;
            out_valid_r  <= out_valid_s;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.opt_o      = opt_r;
    assign bus.delta      = acc_r;
    assign bus.ord_raddr  = ord_raddr_r;
    assign bus.dist_raddr = dist_raddr_r;

endmodule
